ff_exec_core: RTL and testbench
===============================

// Module: ff_exec_core
// PURPOSE
//  Parametrised fetch/execute sequencer; successor to the fixed 16-bit single-loop CPU.
//  Fetches instructions from an external memory controller over a req/ack handshake.
//  Decodes and executes them; ALU results are written back to memory through the same handshake.
//  Adds configurable width, PC wrap, a result base address, a retired-instruction counter and a true halt state.
// PARAMETERS
//  DATA_W   16      instruction/data word width; must satisfy DATA_W >= 16 and (DATA_W-4)%3==0
//  ADDR_W   17      memory word-address width; PC width
//  RES_BASE 'h100   base address for ALU result writes (ADDR_W bits)
//  COUNT_W  16      width of retired-instruction counter
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       synchronous reset, active-low
//  ena        in   1       1=advance; 0=hold all state, outputs frozen
//  mem_addr   out  ADDR_W  request address
//  mem_wdata  out  DATA_W  write data
//  mem_we     out  1       1=write request, 0=read request
//  mem_req    out  1       request valid; held until mem_ack
//  mem_ack    in   1       one-cycle completion pulse from controller
//  mem_rdata  in   DATA_W  read data, valid only in the mem_ack cycle
//  pc         out  ADDR_W  current instruction address
//  halted     out  1       1 once HLT has executed
//  retired    out  COUNT_W retired-instruction count, saturating
// BEHAVIOUR
//  Fields: F=(DATA_W-4)/3; OP=ins[DATA_W-1-:4], A=ins[DATA_W-5-:F], B=next F bits, C=low F bits.
//  Reset (rst_n=0 at posedge, regardless of ena): state=FETCH; pc=0; mem_req=0; mem_we=0;
//  mem_addr=0; mem_wdata=0; halted=0; retired=0. Reset mid-request drops mem_req at that edge.
//  The controller is reset by the same rst_n.
//  FSM states: FETCH, EXEC, STORE, HALT.
//  FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ack: latch mem_rdata into ir; mem_req=0; go to EXEC.
//  EXEC: one cycle. Decodes ir. Increments retired (saturates at all-ones).
//  ALU ops: mem_wdata<=result; mem_addr<=RES_BASE+C (mod 2^ADDR_W); go to STORE.
//  Other ops: update pc; go to FETCH.
//  STORE: mem_req=1, mem_we=1. On mem_ack: mem_req=0, mem_we=0; pc<=pc+1; go to FETCH.
//  HALT: mem_req=0; halted=1. Absorbing until reset.
//  mem_req is low for at least 1 cycle between consecutive requests. Minimum 3 cycles/instr (non-ALU).
//  ALU ops: operands A, B are zero-extended to DATA_W; result is truncated to DATA_W.
//   1 ADD A+B | 2 CMP 0 if A==B, 1 if A>B, all-ones if A<B | 3 MUL A*B | 4 SUB A-B (wraps)
//   5 MOD A%B, all-ones if B==0 | 6 AND | 7 OR | 8 XOR | 9 NOT ~A (full width) | 10 SHL A<<B | 11 SHR A>>B
//   Shift amount >= DATA_W gives result 0.
//  Control ops:
//   0 NOP: pc+1
//   12 JMP: pc<=ins[DATA_W-5:0], zero-extended or truncated to ADDR_W
//   13 JZ: if A==0 then pc<={B,C} zero-extended, else pc+1
//   14 JNZ: if A!=0 then pc<={B,C} zero-extended, else pc+1
//   15 HLT: retired counts it; pc unchanged; go to HALT
//  PC arithmetic is mod 2^ADDR_W: pc=all-ones followed by +1 wraps to 0.
//  mem_ack outside FETCH/STORE, or while mem_req=0: ignored.
//  ena=0: FSM, pc, retired and request outputs hold; a pending mem_ack is lost (controller shares ena).
// TESTING
//  Mem[0]=0x1350 (ADD 3,5 -> C=0), mem[1]=0xF000 -> write 0x0008 @0x100; halted=1; retired=2; pc=1.
//  Mem[0]=0x5700 (MOD 7,0) -> write 0xFFFF @0x100. Mem[0]=0x2370 (CMP 3<7) -> write 0xFFFF.
//  Mem[0]=0xD012 (JZ A=0) -> next fetch addr 0x012. Mem[0]=0xE012 (JNZ A=0) -> next fetch addr 1.
//  Preload pc path: JMP to 0xFFF with ADDR_W=12, NOP there -> next fetch at 0x000 (wrap).
//  Random mem_ack delays 1..20 cycles -> mem_req stable until ack; results identical to zero-delay run.
//  rst_n low while FETCH req pending -> next cycle mem_req=0, pc=0; after release, fetch restarts at 0.

Source files
------------

// File: rtl/ff_exec_core.sv
// ff_exec_core: parametrised fetch/execute sequencer.
// Fetches instructions over a req/ack memory handshake, decodes and executes
// them, and writes ALU results back to memory at RES_BASE + C.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   ena            1 = advance, 0 = hold all state
//   mem_addr/mem_wdata/mem_we/mem_req   request to the memory controller
//   mem_ack/mem_rdata                   one-cycle completion and read data
//   pc             current instruction address
//   halted         set once HLT has executed
//   retired        saturating retired-instruction count
module ff_exec_core #(
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       ADDR_W   = 17,
  parameter logic [ADDR_W-1:0] RES_BASE = ADDR_W'('h100),
  parameter int unsigned       COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_we,
  output logic               mem_req,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic [COUNT_W-1:0] retired
);

  localparam int unsigned F_W   = (DATA_W - 4) / 3;
  localparam int unsigned IMM_W = DATA_W - 4;

  localparam logic [3:0] OP_JMP = 4'd12;
  localparam logic [3:0] OP_JZ  = 4'd13;
  localparam logic [3:0] OP_JNZ = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  // Shift amounts at or beyond the word width produce zero.
  localparam logic [DATA_W-1:0] SHIFT_LIM = DATA_W'(DATA_W);

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_STORE,
    S_HALT
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   ir;

  logic [3:0]          op;
  logic [F_W-1:0]      fa;
  logic [F_W-1:0]      fb;
  logic [F_W-1:0]      fc;
  logic [DATA_W-1:0]   a_x;
  logic [DATA_W-1:0]   b_x;
  logic [DATA_W-1:0]   alu_res;
  logic                is_alu;
  logic [ADDR_W-1:0]   pc_inc;
  logic [ADDR_W-1:0]   br_tgt;

  // Instruction field decode
  assign op     = ir[DATA_W-1 -: 4];
  assign fa     = ir[DATA_W-5 -: F_W];
  assign fb     = ir[DATA_W-5-F_W -: F_W];
  assign fc     = ir[F_W-1:0];
  assign a_x    = DATA_W'(fa);
  assign b_x    = DATA_W'(fb);
  assign pc_inc = pc + ADDR_W'(1);
  assign br_tgt = ADDR_W'({fb, fc});
  assign is_alu = (op >= 4'd1) && (op <= 4'd11);

  // ALU: operands zero-extended, result truncated to DATA_W
  always_comb begin
    alu_res = '0;
    case (op)
      4'd1:    alu_res = a_x + b_x;
      4'd2:    alu_res = (fa == fb) ? '0 : ((fa > fb) ? DATA_W'(1) : '1);
      4'd3:    alu_res = a_x * b_x;
      4'd4:    alu_res = a_x - b_x;
      4'd5:    alu_res = (fb == '0) ? '1 : (a_x % b_x);
      4'd6:    alu_res = a_x & b_x;
      4'd7:    alu_res = a_x | b_x;
      4'd8:    alu_res = a_x ^ b_x;
      4'd9:    alu_res = ~a_x;
      4'd10:   alu_res = (b_x >= SHIFT_LIM) ? '0 : (a_x << fb);
      4'd11:   alu_res = (b_x >= SHIFT_LIM) ? '0 : (a_x >> fb);
      default: alu_res = '0;
    endcase
  end

  // Sequencer: each request is raised one cycle after entering FETCH/STORE,
  // so mem_req always has a low cycle between consecutive requests.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      ir        <= '0;
      pc        <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      retired   <= '0;
    end else if (ena) begin
      case (state)
        S_FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            ir      <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_EXEC;
          end
        end

        S_EXEC: begin
          if (retired != '1) begin
            retired <= retired + COUNT_W'(1);
          end
          if (is_alu) begin
            mem_wdata <= alu_res;
            mem_addr  <= RES_BASE + ADDR_W'(fc);
            state     <= S_STORE;
          end else begin
            state <= S_FETCH;
            case (op)
              OP_JMP:  pc <= ADDR_W'(ir[IMM_W-1:0]);
              OP_JZ:   pc <= (fa == '0) ? br_tgt : pc_inc;
              OP_JNZ:  pc <= (fa != '0) ? br_tgt : pc_inc;
              OP_HLT: begin
                halted <= 1'b1;
                state  <= S_HALT;
              end
              default: pc <= pc_inc;
            endcase
          end
        end

        S_STORE: begin
          if (!mem_req) begin
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            pc      <= pc_inc;
            state   <= S_FETCH;
          end
        end

        S_HALT: begin
          mem_req <= 1'b0;
          halted  <= 1'b1;
        end

        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_ff_exec_core.sv
// Bench for ff_exec_core: an ISA-level program interpreter predicts the
// memory transaction stream and final architectural state; a memory
// controller process answers requests and checks them against it.
`timescale 1ns/1ps
module tb_ff_exec_core;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 17;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic          rst_n, ena;
  logic [AW-1:0] mem_addr, pc;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, mem_req, mem_ack, halted;
  logic [CW-1:0] retired;

  // narrow-PC instance for wrap / counter saturation
  logic          rst12_n;
  logic [11:0]   addr12, pc12;
  logic [DW-1:0] wdata12, rdata12;
  logic          we12, req12, ack12, halted12;
  logic [1:0]    retired12;

  ff_exec_core #(.DATA_W(DW), .ADDR_W(AW), .RES_BASE(17'h100), .COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pc(pc), .halted(halted), .retired(retired)
  );

  ff_exec_core #(.DATA_W(DW), .ADDR_W(12), .RES_BASE(12'h100), .COUNT_W(2)) dut12 (
    .clk(clk), .rst_n(rst12_n), .ena(1'b1),
    .mem_addr(addr12), .mem_wdata(wdata12), .mem_we(we12),
    .mem_req(req12), .mem_ack(ack12), .mem_rdata(rdata12),
    .pc(pc12), .halted(halted12), .retired(retired12)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  txn_t          exp_q[$];
  txn_t          obs_q[$];
  txn_t          obs0_q[$];
  logic [DW-1:0] mem [int];
  logic [DW-1:0] model_mem [int];
  int            model_pc, model_ret;
  bit            model_halt;
  bit            rnd_delay, no_ack;
  logic [11:0]   log12[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ISA interpreter over the bench memory image
  task automatic run_model();
    int p, op, a, b, c, r, wa, ins;
    p = 0;
    exp_q.delete();
    model_mem  = mem;
    model_ret  = 0;
    model_halt = 0;
    for (int step = 0; step < 500 && !model_halt; step++) begin
      exp_q.push_back('{1'b0, AW'(p), DW'(0)});
      ins = model_mem.exists(p) ? int'(model_mem[p]) : 0;
      op = (ins >> 12) & 15;
      a  = (ins >> 8) & 15;
      b  = (ins >> 4) & 15;
      c  = ins & 15;
      if (model_ret < 65535) model_ret++;
      if (op >= 1 && op <= 11) begin
        case (op)
          1:  r = a + b;
          2:  r = (a == b) ? 0 : ((a > b) ? 1 : 'hFFFF);
          3:  r = a * b;
          4:  r = a - b;
          5:  r = (b == 0) ? 'hFFFF : a % b;
          6:  r = a & b;
          7:  r = a | b;
          8:  r = a ^ b;
          9:  r = ~a;
          10: r = (b >= 16) ? 0 : (a << b);
          default: r = (b >= 16) ? 0 : (a >> b);
        endcase
        r  = r & 'hFFFF;
        wa = ('h100 + c) % (1 << 17);
        exp_q.push_back('{1'b1, AW'(wa), DW'(r)});
        model_mem[wa] = DW'(r);
        p = (p + 1) % (1 << 17);
      end else begin
        case (op)
          12: p = ins & 'hFFF;
          13: p = (a == 0) ? (b * 16 + c) : (p + 1) % (1 << 17);
          14: p = (a != 0) ? (b * 16 + c) : (p + 1) % (1 << 17);
          15: model_halt = 1;
          default: p = (p + 1) % (1 << 17);
        endcase
      end
    end
    model_pc = p;
  endtask

  // Memory controller for the main instance; checks each completed transaction.
  txn_t cur, prev, snap;
  int   wait_n = 0;
  int   dly    = 1;
  bit   hold_valid = 0;
  logic [34:0] hold_bus;
  logic [33:0] hold_core;

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      cur.we = mem_we; cur.addr = mem_addr; cur.data = mem_wdata;
      if (!rst_n) begin
        mem_ack = 1'b0;
        wait_n  = 0;
      end else begin
        if (ena === 1'b0 && hold_valid) begin
          chk("hold_bus", {mem_req, mem_we, mem_addr, mem_wdata}, hold_bus);
          chk("hold_core", {pc, halted, retired}, hold_core);
        end
        if (mem_ack) begin
          if (ena) begin
            obs_q.push_back(snap);
            if (snap.we) mem[int'(snap.addr)] = snap.data;
            if (exp_q.size() == 0) chk("txn_extra", {snap.we, snap.addr}, 0);
            else begin
              txn_t e;
              e = exp_q.pop_front();
              chk("txn", {snap.we, snap.addr, snap.we ? snap.data : DW'(0)},
                         {e.we, e.addr, e.we ? e.data : DW'(0)});
            end
          end
          mem_ack = 1'b0;
          wait_n  = 0;
        end else if (mem_req && ena && !no_ack) begin
          if (wait_n > 0) chk("req_stable", {cur.we, cur.addr, cur.data}, {prev.we, prev.addr, prev.data});
          else dly = rnd_delay ? int'($urandom_range(1, 20)) : 1;
          prev = cur;
          wait_n++;
          if (wait_n >= dly) begin
            snap      = cur;
            mem_ack   = 1'b1;
            mem_rdata = (!mem_we && mem.exists(int'(mem_addr))) ? mem[int'(mem_addr)] : '0;
          end
        end
      end
      hold_bus   = {mem_req, mem_we, mem_addr, mem_wdata};
      hold_core  = {pc, halted, retired};
      hold_valid = 1;
    end
  end

  // Zero-delay controller for the narrow-PC instance
  initial begin
    ack12   = 1'b0;
    rdata12 = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst12_n) ack12 = 1'b0;
      else if (ack12) ack12 = 1'b0;
      else if (req12) begin
        ack12   = 1'b1;
        rdata12 = we12 ? 16'h0 : (addr12 == 12'h000) ? 16'hCFFF :
                  (addr12 == 12'hFFF) ? 16'h0000 : 16'hF000;
        if (!we12) log12.push_back(addr12);
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_prog(input bit rnd);
    ena       = 1'b1;
    rnd_delay = rnd;
    run_model();
    obs_q.delete();
    reset_dut();
  endtask

  task automatic finish_prog(input string tag, input bit ena_rnd);
    int cyc;
    cyc = 0;
    while (!(halted === 1'b1 && exp_q.size() == 0) && cyc < 8000) begin
      @(negedge clk);
      if (ena_rnd) ena = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    ena = 1'b1;
    chk({tag, "_done"}, cyc < 8000, 1);
    @(negedge clk);
    chk({tag, "_halted"}, halted, 1);
    chk({tag, "_pc"}, pc, model_pc);
    chk({tag, "_retired"}, retired, model_ret);
    chk({tag, "_req_idle"}, mem_req, 0);
  endtask

  initial begin
    rst_n = 1'b0; rst12_n = 1'b0; ena = 1'b1;
    rnd_delay = 0; no_ack = 0;
    repeat (2) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_state", {pc, halted, retired, mem_addr, mem_wdata, mem_we}, 0);

    // ADD 3,5 then HLT
    mem.delete(); mem[0] = 16'h1350; mem[1] = 16'hF000;
    start_prog(0);
    chk("model_add", exp_q[1].data, 16'h0008);
    finish_prog("add", 0);
    if (obs_q.size() >= 3) chk("add_wr", {obs_q[1].we, obs_q[1].addr, obs_q[1].data}, {1'b1, 17'h100, 16'h0008});
    else chk("add_obs_n", obs_q.size(), 3);
    chk("add_lit", {halted, retired, pc}, {1'b1, 16'd2, 17'd1});

    // Modulo by zero
    mem.delete(); mem[0] = 16'h5700; mem[1] = 16'hF000;
    start_prog(0);
    finish_prog("mod0", 0);
    chk("mod0_lit", mem.exists(32'h100) ? mem[32'h100] : 16'h0, 16'hFFFF);

    // CMP 3 < 7
    mem.delete(); mem[0] = 16'h2370; mem[1] = 16'hF000;
    start_prog(0);
    finish_prog("cmp", 0);
    chk("cmp_lit", mem.exists(32'h100) ? mem[32'h100] : 16'h0, 16'hFFFF);

    // JZ taken
    mem.delete(); mem[0] = 16'hD012; mem[18] = 16'hF000;
    start_prog(0);
    finish_prog("jz", 0);
    chk("jz_lit", obs_q.size() >= 2 ? obs_q[1].addr : 17'h1FFFF, 17'h012);

    // JNZ not taken
    mem.delete(); mem[0] = 16'hE012; mem[1] = 16'hF000;
    start_prog(0);
    finish_prog("jnz", 0);
    chk("jnz_lit", obs_q.size() >= 2 ? obs_q[1].addr : 17'h1FFFF, 17'h001);

    // Mixed program over every opcode: zero-delay, then random delays with ena gaps
    mem.delete();
    mem[0]  = 16'h1350; mem[1]  = 16'h2731; mem[2]  = 16'h2552; mem[3]  = 16'h3FF3;
    mem[4]  = 16'h4354; mem[5]  = 16'h5F45; mem[6]  = 16'h6CA6; mem[7]  = 16'h7CA7;
    mem[8]  = 16'h8CA8; mem[9]  = 16'h9509; mem[10] = 16'hAFFA; mem[11] = 16'hBF2B;
    mem[12] = 16'h0000; mem[13] = 16'hD100; mem[14] = 16'hE120;
    mem[32] = 16'hD030; mem[48] = 16'hC040; mem[64] = 16'hF000;
    start_prog(0);
    chk("model_shl", model_mem.exists(32'h10A) ? model_mem[32'h10A] : 16'h0, 16'h8000);
    chk("model_ret", model_ret, 18);
    finish_prog("mix0", 0);
    chk("mix_sub_lit", mem.exists(32'h104) ? mem[32'h104] : 16'h0, 16'hFFFE);
    chk("mix_mul_lit", mem.exists(32'h103) ? mem[32'h103] : 16'h0, 16'h00E1);
    chk("mix_lit", {retired, pc}, {16'd18, 17'h040});
    obs0_q = obs_q;
    start_prog(1);
    finish_prog("mixr", 1);
    chk("same_len", obs_q.size(), obs0_q.size());
    if (obs_q.size() == obs0_q.size())
      for (int i = 0; i < obs_q.size(); i++)
        chk("same_txn", {obs_q[i].we, obs_q[i].addr, obs_q[i].data},
                        {obs0_q[i].we, obs0_q[i].addr, obs0_q[i].data});

    // Reset while a fetch request is pending
    mem.delete(); mem[0] = 16'h1350; mem[1] = 16'hF000;
    no_ack = 1;
    start_prog(0);
    begin
      int c;
      c = 0;
      while (mem_req !== 1'b1 && c < 20) begin @(negedge clk); c++; end
    end
    chk("rst_mid_req_seen", mem_req, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_pc", pc, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    no_ack = 0;
    finish_prog("rst_mid", 0);
    chk("rst_mid_fetch0", obs_q.size() >= 1 ? obs_q[0].addr : 17'h1FFFF, 17'h000);

    // PC wrap and counter saturation on the 12-bit instance
    log12.delete();
    @(negedge clk);
    rst12_n = 1'b1;
    repeat (40) @(negedge clk);
    if (log12.size() >= 4) begin
      chk("wrap_f0", log12[0], 12'h000);
      chk("wrap_f1", log12[1], 12'hFFF);
      chk("wrap_f2", log12[2], 12'h000);
      chk("wrap_f3", log12[3], 12'hFFF);
    end else chk("wrap_fetch_n", log12.size(), 4);
    chk("sat_retired", retired12, 2'd3);
    chk("wrap_not_halted", halted12, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
